// File: rtl/axi_aes_seq_if.sv
// Stream and AES-core signals of the axi_aes block sequencer.
// master = sequencer side, slave = DMA engine / AES core side.
interface axi_aes_seq_if #(
  parameter int DW = 128,
  parameter int CW = 32
);
  logic [CW-1:0]   m_axis_mm2s_cntrl_tdata;
  logic            m_axis_mm2s_cntrl_tvalid;
  logic            m_axis_mm2s_cntrl_tlast;
  logic            m_axis_mm2s_cntrl_tready;
  logic [DW-1:0]   m_axis_mm2s_tdata;
  logic [DW/8-1:0] m_axis_mm2s_tkeep;
  logic            m_axis_mm2s_tvalid;
  logic            m_axis_mm2s_tlast;
  logic            m_axis_mm2s_tready;
  logic [DW-1:0]   s_axis_s2mm_tdata;
  logic [DW/8-1:0] s_axis_s2mm_tkeep;
  logic            s_axis_s2mm_tvalid;
  logic            s_axis_s2mm_tlast;
  logic            s_axis_s2mm_tready;
  logic [CW-1:0]   s_axis_s2mm_sts_tdata;
  logic [CW/8-1:0] s_axis_s2mm_sts_tkeep;
  logic            s_axis_s2mm_sts_tvalid;
  logic            s_axis_s2mm_sts_tlast;
  logic            s_axis_s2mm_sts_tready;
  logic            aes_decrypt;
  logic            aes_key_load;
  logic            aes_key_done;
  logic            aes_start;
  logic [DW-1:0]   aes_din;
  logic            aes_done;
  logic [DW-1:0]   aes_dout;
  logic            busy;

  modport master (
    input  m_axis_mm2s_cntrl_tdata, m_axis_mm2s_cntrl_tvalid, m_axis_mm2s_cntrl_tlast,
    output m_axis_mm2s_cntrl_tready,
    input  m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tvalid, m_axis_mm2s_tlast,
    output m_axis_mm2s_tready,
    output s_axis_s2mm_tdata, s_axis_s2mm_tkeep, s_axis_s2mm_tvalid, s_axis_s2mm_tlast,
    input  s_axis_s2mm_tready,
    output s_axis_s2mm_sts_tdata, s_axis_s2mm_sts_tkeep, s_axis_s2mm_sts_tvalid,
    output s_axis_s2mm_sts_tlast,
    input  s_axis_s2mm_sts_tready,
    output aes_decrypt, aes_key_load, aes_start, aes_din, busy,
    input  aes_key_done, aes_done, aes_dout
  );

  modport slave (
    output m_axis_mm2s_cntrl_tdata, m_axis_mm2s_cntrl_tvalid, m_axis_mm2s_cntrl_tlast,
    input  m_axis_mm2s_cntrl_tready,
    output m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tvalid, m_axis_mm2s_tlast,
    input  m_axis_mm2s_tready,
    input  s_axis_s2mm_tdata, s_axis_s2mm_tkeep, s_axis_s2mm_tvalid, s_axis_s2mm_tlast,
    output s_axis_s2mm_tready,
    input  s_axis_s2mm_sts_tdata, s_axis_s2mm_sts_tkeep, s_axis_s2mm_sts_tvalid,
    input  s_axis_s2mm_sts_tlast,
    output s_axis_s2mm_sts_tready,
    input  aes_decrypt, aes_key_load, aes_start, aes_din, busy,
    output aes_key_done, aes_done, aes_dout
  );
endinterface

// File: rtl/axi_aes_seq.sv
// Packet sequencer: parses the DMA control header, optionally reloads the key,
// pushes one block at a time through the AES core and closes with a status word.
module axi_aes_seq #(
  parameter int C_M_AXIS_MM2S_TDATA_WIDTH       = 128,
  parameter int C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH = 32,
  parameter int C_CNTRL_WORDS                   = 6,
  parameter int C_BLK_CNT_WIDTH                 = 16
) (
  input  logic          s_axi_aclk,
  input  logic          axi_reset,
  axi_aes_seq_if.master bus
);
  localparam int DW = C_M_AXIS_MM2S_TDATA_WIDTH;
  localparam int CW = C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH;
  localparam int PAD_W = CW - 3 - C_BLK_CNT_WIDTH;
  localparam logic [7:0] HDR_WORDS = 8'(C_CNTRL_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_KEY, S_KEY_WAIT, S_LOAD, S_RUN, S_RUN_WAIT, S_OUT, S_STS
  } state_t;

  state_t state_q, state_d;

  logic                       live_q;
  logic [7:0]                 hdr_cnt_q;
  logic                       hdr_err_q, keep_err_q, decrypt_q, rekey_q, last_q;
  logic [C_BLK_CNT_WIDTH-1:0] blk_cnt_q;
  logic [DW-1:0]              din_q, out_q;
  logic [DW/8-1:0]            keep_q;

  logic cntrl_rdy, data_rdy, out_vld, sts_vld, key_load, start;
  logic cntrl_hs, data_hs, out_hs, sts_hs, rekey_now;
  logic [7:0] hdr_total;

  assign cntrl_hs  = cntrl_rdy & bus.m_axis_mm2s_cntrl_tvalid;
  assign data_hs   = data_rdy & bus.m_axis_mm2s_tvalid;
  assign out_hs    = out_vld & bus.s_axis_s2mm_tready;
  assign sts_hs    = sts_vld & bus.s_axis_s2mm_sts_tready;
  assign hdr_total = (hdr_cnt_q == 8'hFF) ? 8'hFF : hdr_cnt_q + 8'd1;
  // app0 may arrive together with tlast, so the exit decision looks at it directly.
  assign rekey_now = (hdr_cnt_q == 8'd1) ? bus.m_axis_mm2s_cntrl_tdata[1] : rekey_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_axi_aclk or posedge axi_reset) begin
    if (axi_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (cntrl_hs) state_d = bus.m_axis_mm2s_cntrl_tlast ? S_LOAD : S_HDR;
      S_HDR:      if (cntrl_hs && bus.m_axis_mm2s_cntrl_tlast) state_d = rekey_now ? S_KEY : S_LOAD;
      S_KEY:      state_d = bus.aes_key_done ? S_LOAD : S_KEY_WAIT;
      S_KEY_WAIT: if (bus.aes_key_done) state_d = S_LOAD;
      S_LOAD:     if (data_hs) state_d = S_RUN;
      S_RUN:      state_d = bus.aes_done ? S_OUT : S_RUN_WAIT;
      S_RUN_WAIT: if (bus.aes_done) state_d = S_OUT;
      S_OUT:      if (out_hs) state_d = last_q ? S_STS : S_LOAD;
      S_STS:      if (sts_hs) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // live_q holds the control-stream ready low until the first edge after reset.
  always_comb begin
    cntrl_rdy = 1'b0;
    data_rdy  = 1'b0;
    out_vld   = 1'b0;
    sts_vld   = 1'b0;
    key_load  = 1'b0;
    start     = 1'b0;
    unique case (state_q)
      S_IDLE, S_HDR: cntrl_rdy = live_q;
      S_KEY:         key_load  = 1'b1;
      S_LOAD:        data_rdy  = 1'b1;
      S_RUN:         start     = 1'b1;
      S_OUT:         out_vld   = 1'b1;
      S_STS:         sts_vld   = 1'b1;
      default:       ;
    endcase
  end

  // NOTE: datapath registers are reset too, because every output must read 0 in reset.
  always_ff @(posedge s_axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      live_q     <= 1'b0;
      hdr_cnt_q  <= '0;
      hdr_err_q  <= 1'b0;
      keep_err_q <= 1'b0;
      decrypt_q  <= 1'b0;
      rekey_q    <= 1'b0;
      last_q     <= 1'b0;
      blk_cnt_q  <= '0;
      din_q      <= '0;
      keep_q     <= '0;
      out_q      <= '0;
    end else begin
      live_q <= 1'b1;
      if (cntrl_hs) begin
        if (state_q == S_IDLE) begin
          hdr_cnt_q  <= 8'd1;
          hdr_err_q  <= (bus.m_axis_mm2s_cntrl_tdata[CW-1 -: 4] != 4'hA) ||
                        (bus.m_axis_mm2s_cntrl_tlast && HDR_WORDS != 8'd1);
          keep_err_q <= 1'b0;
          blk_cnt_q  <= '0;
          decrypt_q  <= 1'b0;
          rekey_q    <= 1'b0;
        end else begin
          hdr_cnt_q <= hdr_total;
          if (hdr_cnt_q == 8'd1) begin
            decrypt_q <= bus.m_axis_mm2s_cntrl_tdata[0];
            rekey_q   <= bus.m_axis_mm2s_cntrl_tdata[1];
          end
          if (bus.m_axis_mm2s_cntrl_tlast && hdr_total != HDR_WORDS) hdr_err_q <= 1'b1;
        end
      end
      if (data_hs) begin
        din_q  <= bus.m_axis_mm2s_tdata;
        keep_q <= bus.m_axis_mm2s_tkeep;
        last_q <= bus.m_axis_mm2s_tlast;
        if (blk_cnt_q != '1) blk_cnt_q <= blk_cnt_q + C_BLK_CNT_WIDTH'(1);
        if (!bus.m_axis_mm2s_tlast && bus.m_axis_mm2s_tkeep != '1) keep_err_q <= 1'b1;
      end
      if ((state_q == S_RUN || state_q == S_RUN_WAIT) && bus.aes_done) out_q <= bus.aes_dout;
    end
  end

  assign bus.m_axis_mm2s_cntrl_tready = cntrl_rdy;
  assign bus.m_axis_mm2s_tready       = data_rdy;
  assign bus.s_axis_s2mm_tdata        = out_q;
  assign bus.s_axis_s2mm_tkeep        = keep_q;
  assign bus.s_axis_s2mm_tvalid       = out_vld;
  assign bus.s_axis_s2mm_tlast        = out_vld & last_q;
  assign bus.s_axis_s2mm_sts_tdata    = sts_vld ? {1'b1, hdr_err_q, keep_err_q, {PAD_W{1'b0}}, blk_cnt_q}
                                                : '0;
  assign bus.s_axis_s2mm_sts_tkeep    = sts_vld ? '1 : '0;
  assign bus.s_axis_s2mm_sts_tvalid   = sts_vld;
  assign bus.s_axis_s2mm_sts_tlast    = sts_vld;
  assign bus.aes_decrypt              = decrypt_q;
  assign bus.aes_key_load             = key_load;
  assign bus.aes_start                = start;
  assign bus.aes_din                  = din_q;
  assign bus.busy                     = (state_q != S_IDLE);
endmodule

// File: tb/tb_axi_aes_seq.sv
// Scoreboard bench for axi_aes_seq; a second instance with a 4-bit block counter
// runs in lockstep on the same stimulus to reach counter saturation quickly.
module tb_axi_aes_seq;
  localparam logic [127:0] MASK = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_aes_seq_if #(.DW(128), .CW(32)) bus ();
  axi_aes_seq_if #(.DW(128), .CW(32)) bus2 ();

  axi_aes_seq dut (.s_axi_aclk(clk), .axi_reset(rst), .bus(bus));
  axi_aes_seq #(.C_BLK_CNT_WIDTH(4)) dut_sat (.s_axi_aclk(clk), .axi_reset(rst), .bus(bus2));

  assign bus2.m_axis_mm2s_cntrl_tdata  = bus.m_axis_mm2s_cntrl_tdata;
  assign bus2.m_axis_mm2s_cntrl_tvalid = bus.m_axis_mm2s_cntrl_tvalid;
  assign bus2.m_axis_mm2s_cntrl_tlast  = bus.m_axis_mm2s_cntrl_tlast;
  assign bus2.m_axis_mm2s_tdata        = bus.m_axis_mm2s_tdata;
  assign bus2.m_axis_mm2s_tkeep        = bus.m_axis_mm2s_tkeep;
  assign bus2.m_axis_mm2s_tvalid       = bus.m_axis_mm2s_tvalid;
  assign bus2.m_axis_mm2s_tlast        = bus.m_axis_mm2s_tlast;
  assign bus2.s_axis_s2mm_tready       = bus.s_axis_s2mm_tready;
  assign bus2.s_axis_s2mm_sts_tready   = bus.s_axis_s2mm_sts_tready;
  assign bus2.aes_key_done             = bus.aes_key_done;
  assign bus2.aes_done                 = bus.aes_done;
  assign bus2.aes_dout                 = bus.aes_dout;

  int total = 0;
  int bad = 0;
  int core_lat = 3;
  int rst_epoch = 0;
  int pkt_starts = 0;
  int key_cnt = 0;
  int key_pre_starts = -1;

  beat_t       exp_q[$];
  logic [31:0] sts_q[$];
  logic [31:0] sts2_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic dec);
    return dec ? ~d : (d ^ MASK);
  endfunction

  // Behavioural AES core: fixed latency, result is a reversible mix of the block.
  initial begin : core_model
    logic [127:0] d;
    logic         dec;
    int           ep;
    bus.aes_done = 1'b0;
    bus.aes_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.aes_start && !rst) begin
        pkt_starts++;
        d   = bus.aes_din;
        dec = bus.aes_decrypt;
        ep  = rst_epoch;
        repeat (core_lat) @(posedge clk);
        #1;
        if (ep == rst_epoch && !rst) begin
          check("aes_din_stable", bus.aes_din, d);
          bus.aes_dout = core_fn(d, dec);
          bus.aes_done = 1'b1;
          @(posedge clk); #1;
          bus.aes_done = 1'b0;
        end
      end
    end
  end

  initial begin : key_model
    bus.aes_key_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.aes_key_load && !rst) begin
        key_cnt++;
        key_pre_starts = pkt_starts;
        repeat (5) @(posedge clk);
        #1;
        bus.aes_key_done = 1'b1;
        @(posedge clk); #1;
        bus.aes_key_done = 1'b0;
      end
    end
  end

  // Monitor: compare whatever the DUT hands over against the scoreboard queues.
  always @(negedge clk) begin
    beat_t e;
    logic [31:0] s, s2;
    if (!rst && bus.s_axis_s2mm_tvalid && bus.s_axis_s2mm_tready) begin
      if (exp_q.size() == 0) begin
        check("s2mm_unexpected_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("s2mm_data", bus.s_axis_s2mm_tdata, e.data);
        check("s2mm_keep_last", {bus.s_axis_s2mm_tkeep, bus.s_axis_s2mm_tlast}, {e.keep, e.last});
      end
    end
    if (!rst && bus.s_axis_s2mm_sts_tvalid && bus.s_axis_s2mm_sts_tready) begin
      if (sts_q.size() == 0 || sts2_q.size() == 0) begin
        check("sts_unexpected", 1'b1, 1'b0);
      end else begin
        s  = sts_q.pop_front();
        s2 = sts2_q.pop_front();
        check("sts_word", bus.s_axis_s2mm_sts_tdata, s);
        check("sts_keep_last", {bus.s_axis_s2mm_sts_tkeep, bus.s_axis_s2mm_sts_tlast}, 5'h1F);
        check("sts_sat_word", {bus2.s_axis_s2mm_sts_tvalid, bus2.s_axis_s2mm_sts_tdata}, {1'b1, s2});
      end
    end
  end

  task automatic send_cntrl(input logic [31:0] w, input logic last);
    int t = 0;
    bus.m_axis_mm2s_cntrl_tdata  = w;
    bus.m_axis_mm2s_cntrl_tlast  = last;
    bus.m_axis_mm2s_cntrl_tvalid = 1'b1;
    while (!bus.m_axis_mm2s_cntrl_tready && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 1000) check("cntrl_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.m_axis_mm2s_cntrl_tvalid = 1'b0;
    bus.m_axis_mm2s_cntrl_tlast  = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic last);
    int t = 0;
    bus.m_axis_mm2s_tdata  = d;
    bus.m_axis_mm2s_tkeep  = k;
    bus.m_axis_mm2s_tlast  = last;
    bus.m_axis_mm2s_tvalid = 1'b1;
    while (!bus.m_axis_mm2s_tready && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 1000) check("mm2s_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.m_axis_mm2s_tvalid = 1'b0;
    bus.m_axis_mm2s_tlast  = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] w0, input logic [31:0] app0, input int nw);
    for (int i = 0; i < nw; i++)
      send_cntrl((i == 0) ? w0 : (i == 1) ? app0 : 32'(i), i == nw - 1);
  endtask

  function automatic logic [127:0] blk(input int i, input logic [31:0] tag);
    return {32'(i) * 32'h9E3779B9, ~32'(i), 32'hC0FFEE00 + 32'(i), tag};
  endfunction

  // Whole packet: expected status first, then each beat's result as it is issued.
  task automatic packet(input logic [31:0] w0, input logic [31:0] app0, input int nw,
                        input int nb, input int bad_keep_idx, input logic [15:0] last_keep);
    logic herr, kerr;
    logic [127:0] d;
    logic [15:0] k;
    beat_t e;
    herr = (nw != 6) || (w0[31:28] != 4'hA);
    kerr = (bad_keep_idx >= 0) && (bad_keep_idx < nb - 1);
    pkt_starts = 0;
    key_cnt = 0;
    key_pre_starts = -1;
    sts_q.push_back({1'b1, herr, kerr, 13'b0, 16'((nb > 65535) ? 65535 : nb)});
    sts2_q.push_back({1'b1, herr, kerr, 25'b0, 4'((nb > 15) ? 15 : nb)});
    send_hdr(w0, app0, nw);
    for (int i = 0; i < nb; i++) begin
      d = blk(i, w0 ^ app0);
      k = (i == bad_keep_idx) ? 16'h00FF : (i == nb - 1) ? last_keep : 16'hFFFF;
      e.data = core_fn(d, app0[0]);
      e.keep = k;
      e.last = (i == nb - 1);
      exp_q.push_back(e);
      send_beat(d, k, i == nb - 1);
    end
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((sts_q.size() != 0 || bus.busy) && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    check({name, "_complete"}, (t < 5000), 1'b1);
    checki({name, "_beats_drained"}, exp_q.size(), 0);
  endtask

  function automatic logic [8:0] ctrl_outs();
    return {bus.busy, bus.m_axis_mm2s_cntrl_tready, bus.m_axis_mm2s_tready,
            bus.s_axis_s2mm_tvalid, bus.s_axis_s2mm_sts_tvalid, bus.aes_key_load,
            bus.aes_start, bus.aes_decrypt, bus.s_axis_s2mm_tlast};
  endfunction

  initial begin : main
    int t;
    int sc;
    logic stable;
    logic [127:0] d0;
    beat_t e;

    bus.m_axis_mm2s_cntrl_tdata  = '0;
    bus.m_axis_mm2s_cntrl_tvalid = 1'b0;
    bus.m_axis_mm2s_cntrl_tlast  = 1'b0;
    bus.m_axis_mm2s_tdata        = '0;
    bus.m_axis_mm2s_tkeep        = '0;
    bus.m_axis_mm2s_tvalid       = 1'b0;
    bus.m_axis_mm2s_tlast        = 1'b0;
    bus.s_axis_s2mm_tready       = 1'b1;
    bus.s_axis_s2mm_sts_tready   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl_outs", ctrl_outs(), 9'h0);
    check("reset_data_outs", {bus.s_axis_s2mm_tdata, bus.s_axis_s2mm_sts_tdata}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_cntrl_ready", {bus.m_axis_mm2s_cntrl_tready, bus.busy}, 2'b10);

    // Stray core pulses in IDLE are ignored
    bus.aes_done = 1'b1;
    bus.aes_key_done = 1'b1;
    @(posedge clk); #1;
    bus.aes_done = 1'b0;
    bus.aes_key_done = 1'b0;
    @(posedge clk); #1;
    check("stray_pulse_ignored", {bus.busy, bus.s_axis_s2mm_tvalid}, 2'b00);

    // T1: single block, slow core
    core_lat = 10;
    packet(32'hA000_0000, 32'h0, 6, 1, -1, 16'hFFFF);
    wait_done("t1");
    checki("t1_starts", pkt_starts, 1);
    checki("t1_key_loads", key_cnt, 0);

    // T2: rekey + decrypt, 4 blocks
    core_lat = 3;
    packet(32'hA000_0000, 32'h3, 6, 4, -1, 16'hFFFF);
    wait_done("t2");
    checki("t2_starts", pkt_starts, 4);
    checki("t2_key_loads", key_cnt, 1);
    checki("t2_key_before_start", key_pre_starts, 0);
    check("t2_decrypt_held", bus.aes_decrypt, 1'b1);

    // T3: output back-pressure
    bus.s_axis_s2mm_tready = 1'b0;
    fork
      packet(32'hA000_0000, 32'h0, 6, 2, -1, 16'hFFFF);
      begin
        t = 0;
        while (!bus.s_axis_s2mm_tvalid && t < 500) begin
          @(posedge clk); #1; t++;
        end
        check("t3_valid_seen", bus.s_axis_s2mm_tvalid, 1'b1);
        d0 = bus.s_axis_s2mm_tdata;
        sc = pkt_starts;
        stable = 1'b1;
        repeat (20) begin
          @(posedge clk); #1;
          if (!bus.s_axis_s2mm_tvalid || bus.s_axis_s2mm_tdata !== d0 || bus.m_axis_mm2s_tready)
            stable = 1'b0;
        end
        check("t3_hold_stable", stable, 1'b1);
        checki("t3_no_second_start", pkt_starts, sc);
        bus.s_axis_s2mm_tready = 1'b1;
      end
    join
    wait_done("t3");

    // T4: short header with bad magic; then a bad keep on a middle beat
    packet(32'h5000_0000, 32'h0, 4, 2, -1, 16'hFFFF);
    wait_done("t4a");
    packet(32'hA000_0000, 32'h0, 6, 3, 1, 16'h000F);
    wait_done("t4b");

    // T5: reset during RUN of beat 2
    core_lat = 10;
    pkt_starts = 0;
    e.data = core_fn(blk(0, 32'hA000_0000), 1'b0);
    e.keep = 16'hFFFF;
    e.last = 1'b0;
    exp_q.push_back(e);
    send_hdr(32'hA000_0000, 32'h0, 6);
    send_beat(blk(0, 32'hA000_0000), 16'hFFFF, 1'b0);
    send_beat(blk(1, 32'hA000_0000), 16'hFFFF, 1'b0);
    t = 0;
    while (pkt_starts < 2 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    checki("t5_in_run", pkt_starts, 2);
    rst = 1'b1;
    rst_epoch++;
    #1;
    check("t5_reset_ctrl_outs", ctrl_outs(), 9'h0);
    @(posedge clk); #1;
    check("t5_reset_data_outs", {bus.s_axis_s2mm_tdata, bus.aes_din}, '0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    packet(32'hA000_0000, 32'h0, 6, 1, -1, 16'hFFFF);
    wait_done("t5");

    // T6: long packet; the 4-bit instance saturates at 0xF
    core_lat = 1;
    packet(32'hA000_0000, 32'h0, 6, 20, -1, 16'hFFFF);
    wait_done("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
